// File: rtl/zeri_mod_n.sv
// Counts zero (or one) bits of each qualified W-bit sample modulo MOD.
// data_o flags a running count of 0 mod MOD; wrap_o pulses when an update wraps.
module zeri_mod_n #(
    parameter int W     = 1,
    parameter int MOD   = 2,
    parameter int CNT_W = $clog2(MOD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     data,
    input  logic             valid_i,
    input  logic             mode_i,
    input  logic             clear_i,
    output logic             data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o
);

    // Six spare bits hold any k up to 32 plus the largest count without overflow.
    localparam int SUM_W = CNT_W + 6;

    logic [SUM_W-1:0] ones;
    logic [SUM_W-1:0] k;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_mod;
    logic             wrap_next;

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < W; i++) begin
            ones = ones + SUM_W'(data[i]);
        end
        k         = mode_i ? ones : (SUM_W'(W) - ones);
        sum       = SUM_W'(count_o) + k;
        sum_mod   = sum % SUM_W'(MOD);
        wrap_next = (sum >= SUM_W'(MOD)) || ((k != '0) && (sum_mod == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_o <= '0;
            wrap_o  <= 1'b0;
        end else if (clear_i) begin
            count_o <= '0;
            wrap_o  <= 1'b0;
        end else if (valid_i) begin
            count_o <= sum_mod[CNT_W-1:0];
            wrap_o  <= wrap_next;
        end else begin
            wrap_o  <= 1'b0;
        end
    end

    assign data_o = (count_o == '0);

endmodule

// File: tb/tb_zeri_mod_n.sv
// Directed and randomised checks of zeri_mod_n across several W/MOD configurations.
module tb_zeri_mod_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rst, vld, md, clr;
    logic [4:0] dout, wrp;
    logic [0:0]  d0;
    logic [7:0]  d1, d2;
    logic [3:0]  d3;
    logic [15:0] d4;
    logic [0:0]  c0;
    logic [1:0]  c1;
    logic [2:0]  c2;
    logic [1:0]  c3;
    logic [2:0]  c4;

    int checks = 0;
    int errors = 0;

    zeri_mod_n #(.W(1), .MOD(2)) u0 (
        .clk(clk), .reset(rst[0]), .data(d0), .valid_i(vld[0]), .mode_i(md[0]),
        .clear_i(clr[0]), .data_o(dout[0]), .count_o(c0), .wrap_o(wrp[0]));
    zeri_mod_n #(.W(8), .MOD(3)) u1 (
        .clk(clk), .reset(rst[1]), .data(d1), .valid_i(vld[1]), .mode_i(md[1]),
        .clear_i(clr[1]), .data_o(dout[1]), .count_o(c1), .wrap_o(wrp[1]));
    zeri_mod_n #(.W(8), .MOD(5)) u2 (
        .clk(clk), .reset(rst[2]), .data(d2), .valid_i(vld[2]), .mode_i(md[2]),
        .clear_i(clr[2]), .data_o(dout[2]), .count_o(c2), .wrap_o(wrp[2]));
    zeri_mod_n #(.W(4), .MOD(4)) u3 (
        .clk(clk), .reset(rst[3]), .data(d3), .valid_i(vld[3]), .mode_i(md[3]),
        .clear_i(clr[3]), .data_o(dout[3]), .count_o(c3), .wrap_o(wrp[3]));
    zeri_mod_n #(.W(16), .MOD(7)) u4 (
        .clk(clk), .reset(rst[4]), .data(d4), .valid_i(vld[4]), .mode_i(md[4]),
        .clear_i(clr[4]), .data_o(dout[4]), .count_o(c4), .wrap_o(wrp[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Triplet check of one DUT against expected count/data_o/wrap_o.
    task automatic chk3(input string tag, input int idx, input logic [31:0] cnt,
                        input logic [31:0] ecnt, input logic ewrap);
        chk({tag, ".count"}, cnt, ecnt);
        chk({tag, ".data_o"}, 32'(dout[idx]), 32'(ecnt == 0));
        chk({tag, ".wrap"}, 32'(wrp[idx]), 32'(ewrap));
    endtask

    int m_c;
    logic m_w;
    int kk, ss;
    logic [0:0] s0 [5];
    logic [0:0] e_do [5];
    logic [0:0] e_wr [5];

    initial begin
        rst = '1; vld = '1; md = '0; clr = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;

        // Reset held two cycles with valid samples present.
        for (int r = 0; r < 2; r++) begin
            tick();
            chk3("rst0", 0, 32'(c0), 0, 1'b0);
            chk3("rst1", 1, 32'(c1), 0, 1'b0);
            chk3("rst2", 2, 32'(c2), 0, 1'b0);
            chk3("rst3", 3, 32'(c3), 0, 1'b0);
            chk3("rst4", 4, 32'(c4), 0, 1'b0);
        end
        rst = '0; vld = '0;

        // W=1 MOD=2 mode 0, stream 0,1,0,0,1.
        s0 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        e_do = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        e_wr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vld[0] = 1'b1; md[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d0 = s0[i];
            tick();
            chk("w1.data_o", 32'(dout[0]), 32'(e_do[i]));
            chk("w1.wrap", 32'(wrp[0]), 32'(e_wr[i]));
        end
        vld[0] = 1'b0;

        // W=8 MOD=3 mode 0: k=8 then k=1.
        vld[1] = 1'b1; md[1] = 1'b0; d1 = 8'h00;
        tick(); chk3("m3a", 1, 32'(c1), 2, 1'b1);
        d1 = 8'hFE;
        tick(); chk3("m3b", 1, 32'(c1), 0, 1'b1);
        vld[1] = 1'b0;

        // W=8 MOD=5 mode 1 with a clear that discards its sample.
        vld[2] = 1'b1; md[2] = 1'b1; d2 = 8'h0F;
        tick(); chk3("m5a", 2, 32'(c2), 4, 1'b0);
        clr[2] = 1'b1;
        tick(); chk3("m5clr", 2, 32'(c2), 0, 1'b0);
        clr[2] = 1'b0; d2 = 8'h03;
        tick(); chk3("m5b", 2, 32'(c2), 2, 1'b0);
        vld[2] = 1'b0;

        // W=4 MOD=4: landing exactly on MOD, idle gap, then k=0.
        vld[3] = 1'b1; md[3] = 1'b1; d3 = 4'hF;
        tick(); chk3("m4a", 3, 32'(c3), 0, 1'b1);
        vld[3] = 1'b0;
        tick(); chk3("m4idle", 3, 32'(c3), 0, 1'b0);
        vld[3] = 1'b1; md[3] = 1'b0;
        tick(); chk3("m4k0", 3, 32'(c3), 0, 1'b0);
        vld[3] = 1'b0;

        // Randomised W=16 MOD=7 against a plain-arithmetic model.
        m_c = 0; m_w = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            rst[4] = ($urandom_range(99) < 2);
            clr[4] = ($urandom_range(99) < 5);
            vld[4] = ($urandom_range(99) < 70);
            md[4]  = 1'($urandom);
            d4     = 16'($urandom);
            if (rst[4] || clr[4]) begin
                m_c = 0; m_w = 1'b0;
            end else if (vld[4]) begin
                kk  = md[4] ? $countones(d4) : 16 - $countones(d4);
                ss  = m_c + kk;
                m_c = ss % 7;
                m_w = (ss >= 7) || (kk > 0 && m_c == 0);
            end else begin
                m_w = 1'b0;
            end
            tick();
            chk3("rnd", 4, 32'(c4), 32'(m_c), m_w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
